// File: rtl/pipe_stage_buf_pkg.sv
// Shared pipeline payload field widths, pack offsets and per-boundary payload widths.
package pipe_stage_buf_pkg;

    // Stage payload field widths
    localparam int unsigned WORD_ADDR_BUS     = 30;
    localparam int unsigned DATA_WIDTH_INSN   = 32;
    localparam int unsigned DATA_WIDTH_ALU_OP = 4;
    localparam int unsigned DATA_WIDTH_MEM_OP = 2;
    localparam int unsigned DATA_WIDTH_GPR    = 32;

    // IF/ID pack offsets: {insn, pc}
    localparam int unsigned IF_ID_PC_LSB   = 0;
    localparam int unsigned IF_ID_INSN_LSB = IF_ID_PC_LSB + WORD_ADDR_BUS;
    localparam int unsigned IF_ID_PAYLOAD_W = IF_ID_INSN_LSB + DATA_WIDTH_INSN;

    // ID/EX pack offsets: {gpr_b, gpr_a, mem_op, alu_op, pc}
    localparam int unsigned ID_EX_PC_LSB     = 0;
    localparam int unsigned ID_EX_ALU_OP_LSB = ID_EX_PC_LSB + WORD_ADDR_BUS;
    localparam int unsigned ID_EX_MEM_OP_LSB = ID_EX_ALU_OP_LSB + DATA_WIDTH_ALU_OP;
    localparam int unsigned ID_EX_GPR_A_LSB  = ID_EX_MEM_OP_LSB + DATA_WIDTH_MEM_OP;
    localparam int unsigned ID_EX_GPR_B_LSB  = ID_EX_GPR_A_LSB + DATA_WIDTH_GPR;
    localparam int unsigned ID_EX_PAYLOAD_W  = ID_EX_GPR_B_LSB + DATA_WIDTH_GPR;

    // EX/MEM pack offsets: {store_data, alu_result, mem_op, pc}
    localparam int unsigned EX_MEM_PC_LSB     = 0;
    localparam int unsigned EX_MEM_MEM_OP_LSB = EX_MEM_PC_LSB + WORD_ADDR_BUS;
    localparam int unsigned EX_MEM_RESULT_LSB = EX_MEM_MEM_OP_LSB + DATA_WIDTH_MEM_OP;
    localparam int unsigned EX_MEM_STORE_LSB  = EX_MEM_RESULT_LSB + DATA_WIDTH_GPR;
    localparam int unsigned EX_MEM_PAYLOAD_W  = EX_MEM_STORE_LSB + DATA_WIDTH_GPR;

endpackage

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register with valid/ready handshake, synchronous flush and
// optional two-entry skid storage (SKID=1) that decouples in_ready from out_ready.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = 128,
    parameter bit          SKID      = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [1:0]           occupancy
);

    // Encoding equals occupancy so the state register drives it directly.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    if (SKID) begin : g_skid
        state_e               state_q, state_d;
        logic [PAYLOAD_W-1:0] main_q, main_d;
        logic [PAYLOAD_W-1:0] skid_q, skid_d;

        // Next-state and payload steering; flush overrides everything.
        always_comb begin
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;
            unique case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        main_d  = in_payload;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (in_fire && out_fire) begin
                        main_d = in_payload;
                    end else if (in_fire) begin
                        skid_d  = in_payload;
                        state_d = StFull;
                    end else if (out_fire) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
            if (flush) begin
                // Same-cycle push is discarded; payload contents are don't-care once empty.
                state_d = StEmpty;
                main_d  = main_q;
                skid_d  = skid_q;
            end
        end

        // State and payload registers.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= StEmpty;
                main_q  <= '0;
                skid_q  <= '0;
            end else begin
                state_q <= state_d;
                main_q  <= main_d;
                skid_q  <= skid_d;
            end
        end

        // in_ready comes from registered state only, no path from out_ready.
        always_comb begin
            in_ready    = (state_q != StFull);
            out_valid   = (state_q != StEmpty);
            out_payload = main_q;
            occupancy   = state_q;
        end
    end else begin : g_single
        logic                 valid_q, valid_d;
        logic [PAYLOAD_W-1:0] main_q, main_d;

        // Single-entry next state; a simultaneous push and pop replaces with no bubble.
        always_comb begin
            valid_d = valid_q;
            main_d  = main_q;
            if (flush) begin
                valid_d = 1'b0;
            end else if (in_fire) begin
                valid_d = 1'b1;
                main_d  = in_payload;
            end else if (out_fire) begin
                valid_d = 1'b0;
            end
        end

        // Valid flag and payload register.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                valid_q <= 1'b0;
                main_q  <= '0;
            end else begin
                valid_q <= valid_d;
                main_q  <= main_d;
            end
        end

        // Combinational in_ready: accept when empty or when draining this cycle.
        always_comb begin
            in_ready    = ~valid_q | out_ready;
            out_valid   = valid_q;
            out_payload = main_q;
            occupancy   = {1'b0, valid_q};
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench: SKID=1 instance for streaming, backpressure, drain, flush
// and async reset; SKID=0 instance for the single-register mode.
module tb_pipe_stage_buf;

    localparam int unsigned W = 32;

    logic         clk;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_payload;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_payload;
    logic [1:0]   occupancy;

    logic         s0_flush;
    logic         s0_in_valid;
    logic         s0_in_ready;
    logic [W-1:0] s0_in_payload;
    logic         s0_out_valid;
    logic         s0_out_ready;
    logic [W-1:0] s0_out_payload;
    logic [1:0]   s0_occupancy;

    int checks;
    int failures;

    pipe_stage_buf #(.PAYLOAD_W(W), .SKID(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_payload (in_payload),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_payload(out_payload),
        .occupancy  (occupancy)
    );

    pipe_stage_buf #(.PAYLOAD_W(W), .SKID(1'b0)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .flush      (s0_flush),
        .in_valid   (s0_in_valid),
        .in_ready   (s0_in_ready),
        .in_payload (s0_in_payload),
        .out_valid  (s0_out_valid),
        .out_ready  (s0_out_ready),
        .out_payload(s0_out_payload),
        .occupancy  (s0_occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; checks then happen mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_payload = '0;
        s0_flush = 1'b0; s0_in_valid = 1'b0; s0_out_ready = 1'b0; s0_in_payload = '0;
        #3;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (out_payload !== 32'h0) begin
            failures++; $display("FAIL reset_out_payload got=%h exp=0", out_payload);
        end
        checks++;
        if (occupancy !== 2'd0) begin
            failures++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        checks++;
        if (s0_in_ready !== 1'b1 || s0_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_s0 in_ready=%b out_valid=%b exp 1/0", s0_in_ready, s0_out_valid);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_stream();
        logic [W-1:0] vals [3];
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_payload = vals[i];
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_payload !== vals[i]) begin
                failures++;
                $display("FAIL stream_out[%0d] got v=%b d=%h exp v=1 d=%h",
                         i, out_valid, out_payload, vals[i]);
            end
            checks++;
            if (occupancy !== 2'd1 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL stream_occ[%0d] got occ=%0d rdy=%b exp occ=1 rdy=1",
                         i, occupancy, in_ready);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            failures++;
            $display("FAIL stream_empty got v=%b occ=%0d exp v=0 occ=0", out_valid, occupancy);
        end
    endtask

    task automatic test_backpressure();
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_payload = 32'hA0;
        tick();
        checks++;
        if (occupancy !== 2'd1 || out_payload !== 32'hA0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_first got occ=%0d d=%h rdy=%b exp occ=1 d=a0 rdy=1",
                     occupancy, out_payload, in_ready);
        end
        in_payload = 32'hA1;
        tick();
        checks++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_full got occ=%0d rdy=%b exp occ=2 rdy=0", occupancy, in_ready);
        end
        in_payload = 32'hA2;
        tick();
        checks++;
        if (occupancy !== 2'd2 || out_payload !== 32'hA0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_hold got occ=%0d v=%b d=%h exp occ=2 v=1 d=a0",
                     occupancy, out_valid, out_payload);
        end
    endtask

    task automatic test_drain();
        logic [W-1:0] exp [3];
        exp[0] = 32'hA0; exp[1] = 32'hA1; exp[2] = 32'hA2;
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        in_payload = 32'hA2;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_payload !== exp[i]) begin
                failures++;
                $display("FAIL drain_out[%0d] got v=%b d=%h exp v=1 d=%h",
                         i, out_valid, out_payload, exp[i]);
            end
            tick();
            // A2 is taken at the edge after FULL drops to ONE.
            if (i == 1) in_valid = 1'b0;
        end
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            failures++;
            $display("FAIL drain_empty got v=%b occ=%0d exp v=0 occ=0", out_valid, occupancy);
        end
    endtask

    task automatic test_flush();
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_payload = 32'h55;
        tick();
        checks++;
        if (out_payload !== 32'h55 || occupancy !== 2'd1) begin
            failures++;
            $display("FAIL flush_pre got d=%h occ=%0d exp d=55 occ=1", out_payload, occupancy);
        end
        flush      = 1'b1;
        in_payload = 32'h66;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL flush_in_ready got=%b exp=1", in_ready);
        end
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            failures++;
            $display("FAIL flush_empty got v=%b occ=%0d exp v=0 occ=0", out_valid, occupancy);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL flush_no_66 got v=%b d=%h exp v=0", out_valid, out_payload);
        end
    endtask

    task automatic test_async_reset();
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_payload = 32'hB0;
        tick();
        in_payload = 32'hB1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (occupancy !== 2'd2) begin
            failures++; $display("FAIL arst_pre got occ=%0d exp=2", occupancy);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_payload !== 32'h0 || occupancy !== 2'd0) begin
            failures++;
            $display("FAIL arst_now got v=%b d=%h occ=%0d exp v=0 d=0 occ=0",
                     out_valid, out_payload, occupancy);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL arst_after got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid);
        end
    endtask

    task automatic test_skid0();
        s0_out_ready  = 1'b0;
        s0_in_valid   = 1'b1;
        s0_in_payload = 32'h70;
        #1;
        checks++;
        if (s0_in_ready !== 1'b1) begin
            failures++; $display("FAIL s0_empty_ready got=%b exp=1", s0_in_ready);
        end
        tick();
        checks++;
        if (s0_out_valid !== 1'b1 || s0_out_payload !== 32'h70 || s0_occupancy !== 2'd1) begin
            failures++;
            $display("FAIL s0_load got v=%b d=%h occ=%0d exp v=1 d=70 occ=1",
                     s0_out_valid, s0_out_payload, s0_occupancy);
        end
        s0_in_payload = 32'h71;
        checks++;
        if (s0_in_ready !== 1'b0) begin
            failures++; $display("FAIL s0_blocked_ready got=%b exp=0", s0_in_ready);
        end
        tick();
        checks++;
        if (s0_out_payload !== 32'h70 || s0_out_valid !== 1'b1) begin
            failures++;
            $display("FAIL s0_hold got v=%b d=%h exp v=1 d=70", s0_out_valid, s0_out_payload);
        end
        s0_out_ready  = 1'b1;
        s0_in_payload = 32'h77;
        #1;
        checks++;
        if (s0_in_ready !== 1'b1) begin
            failures++; $display("FAIL s0_pass_ready got=%b exp=1", s0_in_ready);
        end
        tick();
        checks++;
        if (s0_out_valid !== 1'b1 || s0_out_payload !== 32'h77) begin
            failures++;
            $display("FAIL s0_replace got v=%b d=%h exp v=1 d=77", s0_out_valid, s0_out_payload);
        end
        s0_in_valid = 1'b0;
        tick();
        checks++;
        if (s0_out_valid !== 1'b0 || s0_occupancy !== 2'd0) begin
            failures++;
            $display("FAIL s0_drain got v=%b occ=%0d exp v=0 occ=0", s0_out_valid, s0_occupancy);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_drain();
        test_flush();
        test_async_reset();
        test_skid0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
